// File: rtl/memory_pkg.sv
// Shared types and helpers for the tiny16 main memory.
package memory_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_BYTE_W = 8;
  localparam int STRB_W     = DEF_DATA_W / DEF_BYTE_W;
  // Widest word strb_merge handles; callers zero-extend and truncate around it.
  localparam int MERGE_W    = 64;

  function automatic logic [MERGE_W-1:0] strb_merge(
    input logic [MERGE_W-1:0] old_word,
    input logic [MERGE_W-1:0] new_word,
    input logic [MERGE_W-1:0] strb,
    input int                 byte_w
  );
    logic [MERGE_W-1:0] res;
    for (int i = 0; i < MERGE_W; i++) begin
      res[i] = strb[i / byte_w] ? new_word[i] : old_word[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/memory_clear.sv
// Clear engine: CLEAR/READY FSM walking a counter over every word of the array.
module memory_clear
  import memory_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int DEPTH          = 1 << CNT_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  output logic             busy_o,
  output logic             clr_we_o,
  output logic [CNT_W-1:0] clr_addr_o
);

  localparam mem_state_t       RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH - 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_STATE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: clr is only honoured from READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = READY;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READY: begin
        if (clr_i) begin
          state_d = CLEAR;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = READY;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/memory_array.sv
// tiny16 main memory: byte-strobed write port, registered read port with
// write-first bypass, and a clear engine that owns the write port while busy.
module memory_array
  import memory_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 1 << ADDR_W,
  parameter int BYTE_W         = DEF_BYTE_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_en,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [DATA_W/BYTE_W-1:0] in_strb,
  input  logic                     out_en,
  input  logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     clr,
  output logic                     busy
);

  localparam int                LANES   = DATA_W / BYTE_W;
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              clr_we_s;
  logic [IDX_W-1:0]  clr_addr_s;
  logic              wr_rng_s, rd_rng_s, wr_ok_s, rd_ok_s, bypass_s;
  logic [LANES-1:0]  we_lane_s;
  logic [IDX_W-1:0]  waddr_s;
  logic [DATA_W-1:0] wdata_s, rd_old_s, rd_word_s;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  memory_clear #(
    .CNT_W         (IDX_W),
    .DEPTH         (DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .busy_o    (busy),
    .clr_we_o  (clr_we_s),
    .clr_addr_o(clr_addr_s)
  );

  // A clr pulse in READY swallows any request issued alongside it.
  assign wr_rng_s = ({1'b0, in_addr} < DEPTH_L);
  assign rd_rng_s = ({1'b0, out_addr} < DEPTH_L);
  assign wr_ok_s  = !busy && !clr && in_en && wr_rng_s;
  assign rd_ok_s  = !busy && !clr && out_en;
  assign bypass_s = wr_ok_s && (in_addr == out_addr);

  // Write-port mux between the clear engine and the external port.
  always_comb begin
    we_lane_s = {LANES{1'b0}};
    waddr_s   = in_addr[IDX_W-1:0];
    wdata_s   = in_data;
    if (clr_we_s) begin
      we_lane_s = {LANES{1'b1}};
      waddr_s   = clr_addr_s;
      wdata_s   = {DATA_W{1'b0}};
    end else if (wr_ok_s) begin
      we_lane_s = in_strb;
    end else begin
      we_lane_s = {LANES{1'b0}};
    end
  end

  // Byte-lane RAM write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we_lane_s[l]) begin
        mem_q[waddr_s][l*BYTE_W +: BYTE_W] <= wdata_s[l*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rd_old_s = mem_q[out_addr[IDX_W-1:0]];

  // Read data select: out-of-range reads return zero, colliding writes are merged in.
  always_comb begin
    rd_word_s   = rd_old_s;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (!rd_rng_s) begin
      rd_word_s = {DATA_W{1'b0}};
    end else if (bypass_s) begin
      rd_word_s = DATA_W'(strb_merge(MERGE_W'(rd_old_s), MERGE_W'(in_data),
                                     MERGE_W'(in_strb), BYTE_W));
    end else begin
      rd_word_s = rd_old_s;
    end
    if (rd_ok_s) begin
      out_data_d  = rd_word_s;
      out_valid_d = 1'b1;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_memory_array.sv
// Directed bench: a 16-word/5-bit-address instance and a 64-word/16-bit-address
// instance share stimulus; expected reads are queued and popped per DUT.
module tb_memory_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_en, out_en, clr;
  logic [15:0] in_addr, in_data, out_addr;
  logic [1:0]  in_strb;
  logic [15:0] od_s, od_b;
  logic        ov_s, ov_b, busy_s, busy_b;

  int          total = 0;
  int          bad   = 0;
  int          n;
  logic        ev_s = 1'b0, ev_b = 1'b0;
  logic [15:0] q_s[$], q_b[$];

  always #5 clk = ~clk;

  memory_array #(.DATA_W(16), .ADDR_W(5), .DEPTH(16), .BYTE_W(8), .CLEAR_ON_RESET(1)) u_small (
    .clk(clk), .rst(rst), .in_en(in_en), .in_addr(in_addr[4:0]), .in_data(in_data),
    .in_strb(in_strb), .out_en(out_en), .out_addr(out_addr[4:0]), .out_data(od_s),
    .out_valid(ov_s), .clr(clr), .busy(busy_s)
  );

  memory_array #(.DATA_W(16), .ADDR_W(16), .DEPTH(64), .BYTE_W(8), .CLEAR_ON_RESET(1)) u_big (
    .clk(clk), .rst(rst), .in_en(in_en), .in_addr(in_addr), .in_data(in_data),
    .in_strb(in_strb), .out_en(out_en), .out_addr(out_addr), .out_data(od_b),
    .out_valid(ov_b), .clr(clr), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_en = 1'b0; in_addr = 16'h0000; in_data = 16'h0000; in_strb = 2'b00;
    out_en = 1'b0; out_addr = 16'h0000; clr = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
    in_en = 1'b1; in_addr = a; in_data = d; in_strb = s;
  endtask

  // Read accepted by both instances: queue the expected word for each.
  task automatic rd(input logic [15:0] a, input logic [15:0] es, input logic [15:0] eb);
    out_en = 1'b1; out_addr = a;
    ev_s = 1'b1; ev_b = 1'b1;
    q_s.push_back(es); q_b.push_back(eb);
  endtask

  task automatic tick();
    logic [15:0] e;
    @(posedge clk); #1;
    chk("valid_s", 16'(ov_s), 16'(ev_s));
    if (ev_s && q_s.size() > 0) begin e = q_s.pop_front(); chk("data_s", od_s, e); end
    chk("valid_b", 16'(ov_b), 16'(ev_b));
    if (ev_b && q_b.size() > 0) begin e = q_b.pop_front(); chk("data_b", od_b, e); end
    ev_s = 1'b0; ev_b = 1'b0;
    idle();
  endtask

  task automatic count_small_clear(input string tag);
    n = 0;
    while (busy_s && n < 100) begin
      n++;
      tick();
    end
    chk(tag, 16'(n), 16'd16);
  endtask

  task automatic wait_big();
    int m = 0;
    while (busy_b && m < 200) begin
      m++;
      tick();
    end
    chk("big_clear_done", 16'(busy_b), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_s", od_s, 16'h0000);
    chk("rst_valid_s", 16'(ov_s), 16'd0);
    chk("rst_busy_s", 16'(busy_s), 16'd1);
    chk("rst_busy_b", 16'(busy_b), 16'd1);
    @(negedge clk);
    rst = 1'b1;

    // Power-up clear and full readback, one read per cycle.
    count_small_clear("clear_len_reset");
    wait_big();
    for (int a = 0; a < 16; a++) begin
      rd(16'(a), 16'h0000, 16'h0000);
      tick();
    end

    // Full write then read (0x10 is out of range for the small instance).
    wr(16'h0010, 16'hBEEF, 2'b11); tick();
    rd(16'h0010, 16'h0000, 16'hBEEF); tick();
    wr(16'h0010, 16'h12AB, 2'b01); tick();
    rd(16'h0010, 16'h0000, 16'hBEAB); tick();
    wr(16'h0010, 16'hFFFF, 2'b00); tick();
    rd(16'h0010, 16'h0000, 16'hBEAB); tick();

    // Write-first collision; 0x20 aliases to word 0 in the small instance.
    wr(16'h0020, 16'h1234, 2'b11); tick();
    wr(16'h0020, 16'h5555, 2'b10); rd(16'h0020, 16'h5534, 16'h5534); tick();
    rd(16'h0020, 16'h5534, 16'h5534); tick();

    // Out-of-range write 0x13 on the small instance must not touch word 3.
    wr(16'h0003, 16'h0303, 2'b11); tick();
    wr(16'h0013, 16'hAAAA, 2'b11); tick();
    rd(16'h0013, 16'h0000, 16'hAAAA); tick();
    rd(16'h0003, 16'h0303, 16'h0303); tick();
    tick();
    chk("hold_s", od_s, 16'h0303);
    chk("hold_b", od_b, 16'h0303);

    // clr with simultaneous requests: requests dropped, then 16-cycle clear.
    clr = 1'b1; wr(16'h0005, 16'h7777, 2'b11); out_en = 1'b1; out_addr = 16'h0003;
    tick();
    n = 0;
    while (busy_s && n < 100) begin
      n++;
      wr(16'h0005, 16'h7777, 2'b11); out_en = 1'b1; out_addr = 16'h0003;
      if (n == 5) clr = 1'b1;
      tick();
    end
    chk("clear_len_clr", 16'(n), 16'd16);
    wait_big();
    rd(16'h0000, 16'h0000, 16'h0000); tick();
    rd(16'h0003, 16'h0000, 16'h0000); tick();
    rd(16'h0005, 16'h0000, 16'h0000); tick();
    rd(16'h0013, 16'h0000, 16'h0000); tick();

    // Reset in the middle of a clear restarts it from scratch.
    wr(16'h0000, 16'h4242, 2'b11); tick();
    rd(16'h0000, 16'h4242, 16'h4242); tick();
    clr = 1'b1; tick();
    repeat (7) tick();
    rst = 1'b0;
    #2;
    chk("midrst_data_s", od_s, 16'h0000);
    chk("midrst_data_b", od_b, 16'h0000);
    chk("midrst_busy_s", 16'(busy_s), 16'd1);
    chk("midrst_valid_s", 16'(ov_s), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    count_small_clear("clear_len_midrst");
    wait_big();
    rd(16'h0000, 16'h0000, 16'h0000); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
